// File: rtl/display_sequencer_pkg.sv
// Shared types, defaults and helpers for the display sequencer and its dwell timer.

package display_sequencer_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StShow = 1'b1
  } state_e;

  localparam int unsigned DEF_N     = 4;
  localparam int unsigned DEF_W     = 4;
  localparam int unsigned DEF_DWELL = 41;

  // Width needed to hold 0..value-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned width;
    if (value > 1) begin
      width = int'($clog2(value));
    end else begin
      width = 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/display_sequencer_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while running, ticks on the last count of each dwell.

module dwell_timer
  import display_sequencer_pkg::*;
#(
  parameter int unsigned DWELL = DEF_DWELL
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic run_i,
  output logic tick_o
);

  localparam int unsigned CntW = clog2_min1(DWELL);
  localparam logic [CntW-1:0] CntMax = CntW'(DWELL - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_max;

  assign at_max = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = at_max ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = run_i & at_max;

endmodule

// File: rtl/display_sequencer.sv
// Snapshots N sorted values at start and presents them one per DWELL cycles, one-shot or looping.

module display_sequencer
  import display_sequencer_pkg::*;
#(
  parameter  int unsigned N     = DEF_N,
  parameter  int unsigned W     = DEF_W,
  parameter  int unsigned DWELL = DEF_DWELL,
  localparam int unsigned SEL_W = clog2_min1(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*W-1:0]     sorted_nums,
  input  logic               start_display,
  input  logic               stop,
  input  logic               mode_repeat,
  output logic [W-1:0]       partE,
  output logic [SEL_W-1:0]   sel_idx,
  output logic               disp_valid,
  output logic               busy,
  output logic               done
);

  localparam logic [SEL_W-1:0] SelLast = SEL_W'(N - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [W-1:0]     snap_q [N];
  logic [W-1:0]     snap_d [N];
  logic             rpt_q, rpt_d;
  logic             done_q, done_d;
  logic             timer_run, timer_clear, tick;

  // The timer only advances in SHOW without an abort; otherwise it is held at zero.
  assign timer_run   = (state_q == StShow) && !stop;
  assign timer_clear = !timer_run;

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (timer_clear),
    .run_i   (timer_run),
    .tick_o  (tick)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    snap_d  = snap_q;
    rpt_d   = rpt_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_display && !stop) begin
          for (int i = 0; i < int'(N); i++) begin
            snap_d[i] = sorted_nums[i*W +: W];
          end
          rpt_d   = mode_repeat;
          sel_d   = '0;
          state_d = StShow;
        end
      end
      StShow: begin
        if (stop) begin
          sel_d   = '0;
          state_d = StIdle;
        end else if (tick) begin
          if (sel_q != SelLast) begin
            sel_d = sel_q + 1'b1;
          end else if (rpt_q) begin
            sel_d = '0;
          end else begin
            sel_d   = '0;
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      snap_q  <= '{default: '0};
      rpt_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      snap_q  <= snap_d;
      rpt_q   <= rpt_d;
      done_q  <= done_d;
    end
  end

  assign busy       = (state_q == StShow);
  assign disp_valid = busy;
  assign partE      = busy ? snap_q[sel_q] : '0;
  assign sel_idx    = sel_q;
  assign done       = done_q;

`ifndef SYNTHESIS
  done_not_busy_a : assert property (@(posedge clk) disable iff (rst) done |-> !busy);
  sel_in_range_a  : assert property (@(posedge clk) disable iff (rst) sel_q <= SelLast);
`endif

endmodule

// File: doc/display_sequencer.md
Name: display_sequencer

Overview:
- Parametrised next-generation output sequencer for the sorter.
- Snapshots N sorted values of width W when the display starts.
- Presents them one at a time on a single output bus. Each value is held for DWELL clock cycles.
- Adds one-shot and repeat modes, abort, a valid flag, a busy flag and a completion pulse. It sits between the sorting core and the display/LED driver.

Parameters:
- N, 4, number of sorted elements; legal range N >= 2.
- W, 4, width of each element in bits.
- DWELL, 41, cycles each element is held on the output; legal range DWELL >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- sorted_nums  input  N*W  packed elements; element i occupies bits [i*W+W-1 : i*W]; element 0 is shown first.
- start_display  input  1  level or pulse; acted on only in IDLE.
- stop  input  1  synchronous abort.
- mode_repeat  input  1  0 = one-shot, 1 = cycle endlessly; sampled only at start.
- partE  output  W  currently displayed element; 0 when not displaying.
- sel_idx  output  SEL_W  index of the displayed element; SEL_W = max(1, clog2(N)).
- disp_valid  output  1  high while partE carries a snapshot element.
- busy  output  1  high in state SHOW.
- done  output  1  one-cycle pulse when a one-shot sequence completes normally.

Behaviour:
- Reset (asynchronous, any time, including mid-sequence):
  - state = IDLE, cnt = 0, sel = 0, snapshot cleared to 0, repeat flag = 0.
  - Outputs: partE = 0, sel_idx = 0, disp_valid = 0, busy = 0, done = 0.
- Internal counter width is CNT_W = max(1, clog2(DWELL)). cnt counts 0..DWELL-1 and never exceeds DWELL-1.
- State IDLE:
  - If start_display = 1 and stop = 0 at edge k:
    - capture sorted_nums into the snapshot;
    - latch mode_repeat;
    - set sel = 0, cnt = 0, state = SHOW.
  - From cycle k+1: busy = 1, disp_valid = 1, partE = element 0.
  - Start and stop asserted together in IDLE: stop wins and the block stays IDLE.
- State SHOW, each cycle:
  - If stop = 1: next state IDLE; cnt and sel cleared; no done pulse.
  - Else if cnt < DWELL-1: cnt increments.
  - Else (cnt = DWELL-1, end of dwell):
    - cnt returns to 0.
    - If sel < N-1: sel increments.
    - If sel = N-1 and repeat flag = 1: sel wraps to 0 and the block stays in SHOW. The snapshot is not refreshed.
    - If sel = N-1 and repeat flag = 0: state becomes IDLE and done = 1 for exactly the next cycle. That is the same cycle busy and disp_valid first read 0.
- start_display while in SHOW is ignored; there is no restart or re-snapshot.
- start_display still high in the cycle done pulses starts a new sequence at that edge. Busy then rises again one cycle later.
- Changes on sorted_nums during SHOW have no effect on partE.
- Timing:
  - One-shot sequence: busy high for exactly N*DWELL cycles; element i is visible in cycles i*DWELL+1 .. (i+1)*DWELL after the start edge.
  - DWELL = 1: a new element every cycle.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, SHOW);
  - a clog2-with-minimum-1 helper function;
  - the default constants DEF_N = 4, DEF_W = 4, DEF_DWELL = 41.
- One sub-module: dwell_timer.
  - Parameter: DWELL.
  - Inputs: clk, rst, clear, run.
  - Output: a tick asserted when cnt = DWELL-1 and run is high.
  - Wrap-around and clearing happen inside it; the top level keeps the FSM, the sel counter, the snapshot and the output mux.

Test Plan:
1. Reset and idle. N=4, W=4, DWELL=41; assert rst mid-stream, then release with no start. Required: partE = 0, sel_idx = 0, busy = 0, disp_valid = 0, done = 0 throughout.
2. One-shot sequence. Inputs {3,9,5,1} (element 0 = 1); 1-cycle start pulse, mode_repeat = 0. Required: partE = 1,5,9,3, each for 41 cycles; busy high for 164 cycles; one-cycle done pulse; then partE = 0.
3. Snapshot isolation. DWELL=3; change sorted_nums to all 0xF one cycle after start. Required: the output still shows the captured values; sel_idx runs 0,0,0,1,1,1,2,2,2,3,3,3.
4. Repeat mode. DWELL=3, mode_repeat = 1. Required: sel_idx wraps 3 -> 0 with no gap; done never asserts. Then assert stop for 1 cycle: busy = 0 next cycle, partE = 0, no done.
5. Edge cases:
   - start and stop together in IDLE: block stays IDLE;
   - start held high throughout: back-to-back sequences, with done coinciding with the re-capture edge;
   - async rst pulsed mid-dwell (between edges): all outputs 0 immediately.
6. N=8, W=6, DWELL=1 with values 0..63 range. Required: a new element every cycle; busy high for 8 cycles; sel_idx counts 0..7.
